// File: rtl/mo_mul_arbiter.sv
// mo_mul_arbiter: round-robin sharing of one pipelined Montgomery multiplier (mo_mul)
// among N_REQ requesters. A tag pipe tracks the owner of each in-flight op, so results
// come back in issue order.
// Optional feature macro: MO_MUL_ARB_RANGE_CHK_EN. When it is defined, operands >= `Q are
// accepted but dropped, and err pulses. When it is undefined, err is tied low.

`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 3
`endif
`ifndef Q
`define Q 3329
`endif

module mo_mul_arbiter #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DW     = `DATA_WIDTH,
    parameter int unsigned STAGES = `MUL_STAGE_CNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0][DW-1:0] req_a,
    input  logic [N_REQ-1:0][DW-1:0] req_b,
    input  logic                     drain,
    output logic [DW-1:0]            mul_a,
    output logic [DW-1:0]            mul_b,
    input  logic signed [DW:0]       mul_c,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic signed [DW:0]       rsp_c,
    output logic                     idle,
    output logic                     err
);

    localparam int unsigned IDW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0]     rr_ptr;
    logic               grant;
    logic [IDW-1:0]     grant_id;
    logic               in_range;
    logic               issue;
    logic               any_in_flight;
    logic signed [DW:0] rsp_c_q;
    tag_t               tag_pipe [STAGES+1];

    // Requester index k places after base, wrapping at N_REQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int unsigned k);
        int unsigned s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IDW'(s);
    endfunction

    // Round-robin pick: first valid requester at or after the pointer, suppressed by drain/reset.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        if (!rst && !drain) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!grant && req_valid[rr_index(rr_ptr, k)]) begin
                    grant    = 1'b1;
                    grant_id = rr_index(rr_ptr, k);
                end
            end
        end
    end

    // One-hot ready for the granted requester.
    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_id] = 1'b1;
    end

`ifdef MO_MUL_ARB_RANGE_CHK_EN
    localparam logic [DW-1:0] Q_LIM = DW'(`Q);

    // Operands must be reduced below Q; out-of-range ops are accepted but never issued.
    always_comb begin
        in_range = (req_a[grant_id] < Q_LIM) && (req_b[grant_id] < Q_LIM);
    end

    // Error pulse one cycle after an out-of-range handshake.
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= grant && !in_range;
    end
`else
    assign in_range = 1'b1;
    assign err      = 1'b0;
`endif

    assign issue = grant && in_range;

    // Pointer, multiplier operands, tag pipe and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            rsp_c_q <= '0;
            for (int unsigned s = 0; s <= STAGES; s++) tag_pipe[s] <= '0;
        end else begin
            if (grant) rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
            if (issue) begin
                mul_a <= req_a[grant_id];
                mul_b <= req_b[grant_id];
            end
            tag_pipe[0] <= '{vld: issue, id: grant_id};
            for (int unsigned s = 1; s <= STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
            if (tag_pipe[STAGES].vld) rsp_c_q <= mul_c;
        end
    end

    // Response decode: last tag stage lines up with mul_c.
    always_comb begin
        rsp_valid = '0;
        if (tag_pipe[STAGES].vld) rsp_valid[tag_pipe[STAGES].id] = 1'b1;
        rsp_c = tag_pipe[STAGES].vld ? mul_c : rsp_c_q;
    end

    // Idle when nothing is in flight and nothing is granted this cycle.
    always_comb begin
        any_in_flight = 1'b0;
        for (int unsigned s = 0; s <= STAGES; s++) any_in_flight = any_in_flight | tag_pipe[s].vld;
        idle = !any_in_flight && !grant;
    end

endmodule
